joyencoder: RTL

- Board-side responder for the two-player serial joystick link.
- Emulates two cascaded 74HC165 parallel-in/serial-out registers, driven by an external poller over joy_load_n / joy_clk / joy_data.
- Captures 16 raw, active-low button levels while load is asserted and shifts them out one bit per joy_clk rising edge.
- Sits in test and bridge designs where the FPGA itself presents a joystick port to a poller inside or outside the FPGA.

---
 rtl/joyencoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/joyencoder.sv
// joyencoder: board-side responder emulating two cascaded 74HC165 shift registers for a two-player joystick link.
// Optional per-button debounce filter is built when JOYENC_DEBOUNCE_EN is defined.
module joyencoder #(
  parameter logic        SER_IN         = 1'b1,
  parameter int unsigned IDLE_TIMEOUT_W = 13
`ifdef JOYENC_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_W     = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  output logic       frame_strobe,
  output logic       link_active
);

  localparam int unsigned SR_W = 16;
  localparam logic [IDLE_TIMEOUT_W-1:0] WD_MAX = '1;

  logic                      r_jclk_s1, r_jclk_s2, r_jclk_h;
  logic                      r_jld_s1, r_jld_s2, r_jld_h;
  logic                      w_clk_rise, w_ld_rise;
  logic [SR_W-1:0]           w_par;
  logic [SR_W-1:0]           r_sr;
  logic                      r_data, r_fs, r_link;
  logic [IDLE_TIMEOUT_W-1:0] r_wd, w_wd_next;

  // Poller pins: two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jclk_s1 <= 1'b1;
      r_jclk_s2 <= 1'b1;
      r_jclk_h  <= 1'b1;
      r_jld_s1  <= 1'b1;
      r_jld_s2  <= 1'b1;
      r_jld_h   <= 1'b1;
    end else begin
      r_jclk_s1 <= joy_clk;
      r_jclk_s2 <= r_jclk_s1;
      r_jclk_h  <= r_jclk_s2;
      r_jld_s1  <= joy_load_n;
      r_jld_s2  <= r_jld_s1;
      r_jld_h   <= r_jld_s2;
    end
  end

  assign w_clk_rise = r_jclk_s2 & ~r_jclk_h;
  assign w_ld_rise  = r_jld_s2 & ~r_jld_h;

`ifdef JOYENC_DEBOUNCE_EN
  logic [SR_W-1:0]       r_btn_s1, r_btn_s2, r_filt;
  logic [DEBOUNCE_W-1:0] r_db_cnt [SR_W];

  // A filtered bit flips only after the raw bit has disagreed for 2^DEBOUNCE_W straight cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1 <= '1;
      r_btn_s2 <= '1;
      r_filt   <= '1;
      for (int i = 0; i < 16; i++) r_db_cnt[i] <= '0;
    end else begin
      r_btn_s1 <= {joy2, joy1};
      r_btn_s2 <= r_btn_s1;
      for (int i = 0; i < 16; i++) begin
        if (r_btn_s2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == '1) begin
          r_filt[i]   <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  assign w_par = r_filt;
`else
  assign w_par = {joy2, joy1};
`endif

  // Load dominates; a shift is suppressed in the cycle load_n is seen rising.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr   <= '1;
      r_data <= 1'b1;
    end else begin
      if (!r_jld_s2) begin
        r_sr <= w_par;
      end else if (w_clk_rise && !w_ld_rise) begin
        r_sr <= {SER_IN, r_sr[SR_W-1:1]};
      end
      r_data <= r_sr[0];
    end
  end

  // Watchdog clears together with the frame strobe and saturates at all-ones.
  always_comb begin
    w_wd_next = r_wd;
    if (w_ld_rise) begin
      w_wd_next = '0;
    end else if (r_wd != WD_MAX) begin
      w_wd_next = r_wd + IDLE_TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd   <= WD_MAX;
      r_link <= 1'b0;
      r_fs   <= 1'b0;
    end else begin
      r_wd   <= w_wd_next;
      r_link <= (w_wd_next != WD_MAX);
      r_fs   <= w_ld_rise;
    end
  end

  assign joy_data     = r_data;
  assign frame_strobe = r_fs;
  assign link_active  = r_link;

endmodule
